// File: rtl/alu_pkg.sv
// Shared types and widths for the execute-stage ALU and adder.
package alu_pkg;

  localparam int unsigned WIDTH   = 64;
  localparam int unsigned SHAMT_W = 6;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

endpackage

// File: rtl/add64.sv
// Combinational WIDTH-bit adder with carry-in; the sum wraps modulo 2^WIDTH.
module add64 #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum
);

  assign sum = x + y + {{(WIDTH-1){1'b0}}, cin};

endmodule

// File: rtl/alu_adder.sv
// Execute-stage ALU plus an independent PC/branch adder, both registered
// with a clock enable for stalls.
module alu_adder
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = alu_pkg::WIDTH,
  parameter int unsigned SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] add_a,
  input  logic [WIDTH-1:0] add_b,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic [WIDTH-1:0] add_out
);

  alu_op_e          op;
  logic [WIDTH-1:0] arith_b;
  logic             arith_cin;
  logic [WIDTH-1:0] arith_sum;
  logic [WIDTH-1:0] pc_sum;
  logic [WIDTH-1:0] alu_d;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0] alu_q;
  logic             zero_q;
  logic [WIDTH-1:0] add_q;

  assign op    = alu_op_e'(alu_sel);
  assign shamt = b[SHAMT_W-1:0];

  // SUB reuses the adder as a + ~b + 1.
  assign arith_b   = (op == ALU_SUB) ? ~b : b;
  assign arith_cin = (op == ALU_SUB);

  add64 #(
    .WIDTH(WIDTH)
  ) u_alu_add (
    .x  (a),
    .y  (arith_b),
    .cin(arith_cin),
    .sum(arith_sum)
  );

  add64 #(
    .WIDTH(WIDTH)
  ) u_pc_add (
    .x  (add_a),
    .y  (add_b),
    .cin(1'b0),
    .sum(pc_sum)
  );

  always_comb begin
    alu_d = '0;
    unique case (op)
      ALU_ADD,
      ALU_SUB: alu_d = arith_sum;
      ALU_AND: alu_d = a & b;
      ALU_OR:  alu_d = a | b;
      ALU_XOR: alu_d = a ^ b;
      ALU_SLL: alu_d = a << shamt;
      ALU_SRL: alu_d = a >> shamt;
      ALU_SLT: alu_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_q  <= '0;
      zero_q <= 1'b1;
      add_q  <= '0;
    end else if (en) begin
      alu_q  <= alu_d;
      zero_q <= (alu_d == '0);
      add_q  <= pc_sum;
    end
  end

  assign alu_out = alu_q;
  assign zero    = zero_q;
  assign add_out = add_q;

endmodule

// File: tb/tb_alu_adder.sv
// Directed-vector bench for alu_adder with hand-computed expectations.
module tb_alu_adder;

  localparam int unsigned W = 64;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   alu_sel;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic [W-1:0] alu_out;
  logic         zero;
  logic [W-1:0] add_out;

  int n_vec;
  int n_err;

  alu_adder #(
    .WIDTH(W),
    .SEL_W(3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .a      (a),
    .b      (b),
    .alu_sel(alu_sel),
    .add_a  (add_a),
    .add_b  (add_b),
    .alu_out(alu_out),
    .zero   (zero),
    .add_out(add_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; outputs sampled likewise.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_vec(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [2:0] sel, input logic [W-1:0] exp, input logic exp_z);
    a       = va;
    b       = vb;
    alu_sel = sel;
    step();
    check({tag, " alu_out"}, alu_out, exp);
    check({tag, " zero"}, {63'd0, zero}, {63'd0, exp_z});
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b0;
    en      = 1'b1;
    a       = 64'd9;
    b       = 64'd9;
    alu_sel = 3'b000;
    add_a   = 64'd100;
    add_b   = 64'd100;

    // 1. reset then PC adder
    step();
    step();
    check("rst alu_out", alu_out, 64'd0);
    check("rst add_out", add_out, 64'd0);
    check("rst zero", {63'd0, zero}, 64'd1);
    rst   = 1'b1;
    add_a = 64'h0;
    add_b = 64'h4;
    step();
    check("pc 0+4", add_out, 64'h4);
    add_a = 64'h4;
    step();
    check("pc 4+4", add_out, 64'h8);

    // 2. arithmetic
    alu_vec("add 5+7", 64'd5, 64'd7, 3'b000, 64'd12, 1'b0);
    alu_vec("sub 5-7", 64'd5, 64'd7, 3'b001, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    alu_vec("sub eq", 64'h1234, 64'h1234, 3'b001, 64'd0, 1'b1);
    alu_vec("add wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b000, 64'd0, 1'b1);

    // 3. logic and shifts
    alu_vec("and", 64'hF0F0, 64'h0FF0, 3'b010, 64'h00F0, 1'b0);
    alu_vec("or", 64'hF0F0, 64'h0FF0, 3'b011, 64'hFFF0, 1'b0);
    alu_vec("xor", 64'hF0F0, 64'h0FF0, 3'b100, 64'hFF00, 1'b0);
    alu_vec("sll", 64'd1, 64'h43, 3'b101, 64'd8, 1'b0);
    alu_vec("srl", 64'h8000_0000_0000_0000, 64'd63, 3'b110, 64'd1, 1'b0);
    alu_vec("sll by 0", 64'h55, 64'h40, 3'b101, 64'h55, 1'b0);

    // 4. signed compare
    alu_vec("slt -1<1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b111, 64'd1, 1'b0);
    alu_vec("slt 1<-1", 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b111, 64'd0, 1'b1);
    alu_vec("slt eq", 64'd42, 64'd42, 3'b111, 64'd0, 1'b1);
    alu_vec("slt min<0", 64'h8000_0000_0000_0000, 64'd0, 3'b111, 64'd1, 1'b0);

    // 5. stall
    add_a = 64'd10;
    add_b = 64'd20;
    alu_vec("pre-stall", 64'd3, 64'd4, 3'b000, 64'd7, 1'b0);
    check("pre-stall add", add_out, 64'd30);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a       = 64'd100 + 64'(i);
      b       = 64'd1;
      add_a   = 64'd1 + 64'(i);
      add_b   = 64'd1;
      step();
      check("stall alu_out", alu_out, 64'd7);
      check("stall add_out", add_out, 64'd30);
      check("stall zero", {63'd0, zero}, 64'd0);
    end
    en = 1'b1;
    step();
    check("resume alu_out", alu_out, 64'd103);
    check("resume add_out", add_out, 64'd4);

    // 6. asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    check("async alu_out", alu_out, 64'd0);
    check("async add_out", add_out, 64'd0);
    check("async zero", {63'd0, zero}, 64'd1);
    step();
    rst = 1'b1;
    en  = 1'b0;
    step();
    check("post-rel stall alu", alu_out, 64'd0);
    check("post-rel stall add", add_out, 64'd0);
    en = 1'b1;
    step();
    check("post-rel alu", alu_out, 64'd103);
    check("post-rel add", add_out, 64'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_adder.md
Name: alu_adder

Overview:
- Execute-stage arithmetic block of the 5-stage RISC-V-style pipeline.
- Contains a 64-bit ALU driven by the 3-bit ALU control from the decode stage, and an independent 64-bit adder used for PC+4 and branch-target computation.
- Both results are registered: one cycle of latency, clock-enable hold, asynchronous active-low reset.
- The free-running clock generator is bench-only and is not part of this block.

Parameters:
- WIDTH, 64, datapath width of the ALU operands, adder operands and results.
- SEL_W, 3, width of the ALU operation select.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset; 0 = reset asserted.
- en  in  1  register enable; 0 holds every output register (pipeline stall).
- a  in  WIDTH  ALU operand A (forwarded rs1 value).
- b  in  WIDTH  ALU operand B (forwarded rs2 value or immediate).
- alu_sel  in  SEL_W  ALU operation code.
- add_a  in  WIDTH  adder operand A (PC).
- add_b  in  WIDTH  adder operand B (constant 4 or shifted immediate).
- alu_out  out  WIDTH  registered ALU result.
- zero  out  1  registered flag, 1 when the registered ALU result is all zeros.
- add_out  out  WIDTH  registered adder sum.

Behaviour:
- Reset, while rst=0, asynchronous:
  - alu_out=0, add_out=0, zero=1.
  - Reset wins over en. Assertion mid-operation discards the pending result immediately.
  - Deassertion is sampled at the next rising edge.
- Rising clk edge with rst=1 and en=1:
  - alu_out <= f(a, b, alu_sel).
  - zero <= (f==0).
  - add_out <= add_a + add_b.
- Rising clk edge with rst=1 and en=0: all outputs hold their previous values.
- Latency: exactly 1 cycle from input to output. One new operation per cycle, no handshake.
- alu_sel encoding:
  - 000 ADD: a+b.
  - 001 SUB: a-b.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLL: a << b[5:0].
  - 110 SRL: logical, a >> b[5:0].
  - 111 SLT: signed a<b gives 1, otherwise 0, zero-extended to WIDTH.
- Arithmetic: ADD, SUB and the adder wrap modulo 2^WIDTH. No carry or overflow outputs.
- Shifts: only b[5:0] is used and upper bits of b are ignored. A shift by 0 returns a unchanged.
- SLT: compares as two's-complement, e.g. 0x8000_0000_0000_0000 < 0 gives 1.
- Every alu_sel value is defined, so the output is never X.
- The ALU and the adder are fully independent and update in the same cycle.

Decomposition:
- Shared package alu_pkg holds:
  - the alu_op_e enum (3-bit: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT);
  - the WIDTH default and the shift-amount width (6).
- One natural sub-module, add64: a combinational WIDTH-bit adder with carry-in.
  - Instance 1: ALU ADD, and SUB with the inverted operand and carry-in=1.
  - Instance 2: the standalone PC/branch adder.
- The ALU case statement and output registers stay in the top module.

Test Plan:
1. Reset, then PC adder: hold rst=0 for 2 cycles, expecting alu_out=0, add_out=0, zero=1. Release rst, then apply add_a=0x0, add_b=0x4, then 0x4 and 0x4. Expect add_out=0x4, then 0x8, one cycle after each input.
2. Arithmetic:
   - a=5, b=7, ADD gives 12 with zero=0.
   - SUB gives 0xFFFF_FFFF_FFFF_FFFE.
   - a=b=0x1234, SUB gives 0 with zero=1.
   - a=0xFFFF_FFFF_FFFF_FFFF, b=1, ADD wraps to 0 with zero=1.
3. Logic and shifts, with a=0xF0F0, b=0x0FF0:
   - AND gives 0x00F0, OR gives 0xFFF0, XOR gives 0xFF00.
   - a=1, b=0x43 (only b[5:0]=3 used): SLL gives 8.
   - a=0x8000_0000_0000_0000, b=63: SRL gives 1.
4. SLT:
   - a=-1, b=1 gives 1.
   - a=1, b=-1 gives 0.
   - a=b gives 0 with zero=1.
5. Stall: drive en=0 for 3 cycles while changing a, b, add_a and add_b. Outputs must hold the last values. When en returns to 1, new results appear one cycle later.
6. Async reset mid-stream: pulse rst low between clock edges. Outputs go to 0/0/1 before the next edge and stay there until the first enabled edge after release.
